// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus_pkg
//  Description : Shared types and constants for the 8088-style bus cycle
//                controller: bus-cycle state encoding, default bus widths,
//                the default watchdog limit and the wait-counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package bus_pkg;

    // Bus-cycle states: T1 address phase, T2 strobe setup, T3/TW data phase,
    // T4 completion / response.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        T1   = 3'd1,
        T2   = 3'd2,
        T3   = 3'd3,
        TW   = 3'd4,
        T4   = 3'd5
    } bus_state_t;

    localparam int DEFAULT_DATA_WIDTH    = 8;
    localparam int DEFAULT_ADDRESS_WIDTH = 20;
    localparam int DEFAULT_WAIT_LIMIT    = 15;

    // Width needed to hold a wait count in the range 0..limit inclusive.
    function automatic int wait_cnt_width(input int limit);
        return $clog2(limit + 1);
    endfunction

    localparam int WAIT_CNT_WIDTH = $clog2(DEFAULT_WAIT_LIMIT + 1);

endpackage : bus_pkg
`default_nettype wire

// File: rtl/bus_cycle_controller_if.sv
`default_nettype none
// ============================================================================
//  Module      : bus_cycle_controller_if
//  Description : Groups the CPU request/response port and the memory-side
//                strobes of the bus cycle controller.
//                  master : CPU + memory side (drives requests, READY, rdata)
//                  slave  : the controller itself
//  Ports       : none (signal bundle only)
//                  req_valid/req_ready/req_write/req_addr/req_wdata - request
//                  bus_ready                                        - READY
//                  ale, mem_wr_*, mem_rd_*                          - memory
//                  resp_valid/resp_rdata/resp_err                   - response
//  Revision    : 1.0 - initial release
// ============================================================================
interface bus_cycle_controller_if
    import bus_pkg::*;
#(
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH
) ();

    // CPU request port
    logic                     req_valid;
    logic                     req_ready;
    logic                     req_write;
    logic [ADDRESS_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0]    req_wdata;

    // 8088 READY
    logic                     bus_ready;

    // Memory side
    logic                     ale;
    logic                     mem_wr_en;
    logic [ADDRESS_WIDTH-1:0] mem_wr_addr;
    logic [DATA_WIDTH-1:0]    mem_wr_data;
    logic                     mem_rd_en;
    logic [ADDRESS_WIDTH-1:0] mem_rd_addr;
    logic [DATA_WIDTH-1:0]    mem_rd_data;

    // Response
    logic                     resp_valid;
    logic [DATA_WIDTH-1:0]    resp_rdata;
    logic                     resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, bus_ready, mem_rd_data,
        input  req_ready, ale, mem_wr_en, mem_wr_addr, mem_wr_data,
               mem_rd_en, mem_rd_addr, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, bus_ready, mem_rd_data,
        output req_ready, ale, mem_wr_en, mem_wr_addr, mem_wr_data,
               mem_rd_en, mem_rd_addr, resp_valid, resp_rdata, resp_err
    );

endinterface : bus_cycle_controller_if
`default_nettype wire

// File: rtl/bus_wait_counter.sv
`default_nettype none
// ============================================================================
//  Module      : bus_wait_counter
//  Description : Counts consecutive wait states of one bus cycle and flags
//                when the count has reached WAIT_LIMIT. Saturates at the
//                limit so it can never wrap back to a "safe" value.
//  Ports       : clk         - clock
//                rst         - asynchronous active-high reset
//                i_clear     - zero the count (new transfer accepted)
//                i_incr      - one more wait state inserted
//                o_limit_hit - count == WAIT_LIMIT
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_wait_counter
    import bus_pkg::*;
#(
    parameter int WAIT_LIMIT = DEFAULT_WAIT_LIMIT
) (
    input  wire clk,
    input  wire rst,
    input  wire i_clear,
    input  wire i_incr,
    output wire o_limit_hit
);

    localparam int CNT_WIDTH = wait_cnt_width(WAIT_LIMIT);
    localparam logic [CNT_WIDTH-1:0] C_LIMIT = CNT_WIDTH'(WAIT_LIMIT);
    localparam logic [CNT_WIDTH-1:0] C_ONE   = CNT_WIDTH'(1);

    logic [CNT_WIDTH-1:0] r_count;
    logic                 w_at_limit;

    assign w_at_limit  = (r_count == C_LIMIT);
    assign o_limit_hit = w_at_limit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_incr && !w_at_limit) begin
            r_count <= r_count + C_ONE;
        end
    end

endmodule : bus_wait_counter
`default_nettype wire

// File: rtl/bus_cycle_controller.sv
`default_nettype none
// ============================================================================
//  Module      : bus_cycle_controller
//  Description : Sequences 8088-style T1-T2-T3-[Tw]-T4 bus cycles between a
//                CPU request port and a byte-wide memory. One transfer in
//                flight; wait states are inserted while READY is low and a
//                watchdog aborts the cycle after WAIT_LIMIT wait states.
//  Ports       : clk - clock, all state on the rising edge
//                rst - asynchronous active-high reset
//                bus - bus_cycle_controller_if.slave (request, READY, memory
//                      strobes/addresses/data, response)
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_cycle_controller
    import bus_pkg::*;
#(
    parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = DEFAULT_ADDRESS_WIDTH,
    parameter int WAIT_LIMIT    = DEFAULT_WAIT_LIMIT
) (
    input  wire                    clk,
    input  wire                    rst,
    bus_cycle_controller_if.slave  bus
);

    // ------------------------------------------------------------------
    // State and latched transfer
    // ------------------------------------------------------------------
    bus_state_t               r_state;
    bus_state_t               w_next;

    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0]    r_wdata;
    logic                     r_write;
    logic                     r_err;
    logic [DATA_WIDTH-1:0]    r_rdata;

    // ------------------------------------------------------------------
    // Decoded control
    // ------------------------------------------------------------------
    logic w_req_ready;
    logic w_accept;
    logic w_data_phase;
    logic w_capture;
    logic w_abort;
    logic w_wait_incr;
    logic w_limit_hit;

    assign w_req_ready  = (r_state == IDLE) || (r_state == T4);
    assign w_accept     = bus.req_valid && w_req_ready;
    assign w_data_phase = (r_state == T3) || (r_state == TW);

    bus_wait_counter #(
        .WAIT_LIMIT (WAIT_LIMIT)
    ) u_wait_counter (
        .clk         (clk),
        .rst         (rst),
        .i_clear     (w_accept),
        .i_incr      (w_wait_incr),
        .o_limit_hit (w_limit_hit)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and per-cycle actions
    // ------------------------------------------------------------------
    always_comb begin
        w_next      = r_state;
        w_capture   = 1'b0;
        w_abort     = 1'b0;
        w_wait_incr = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = T1;
                end
            end
            T1: begin
                w_next = T2;
            end
            T2: begin
                w_next = T3;
            end
            T3, TW: begin
                if (bus.bus_ready) begin
                    // READY wins over the watchdog: a cycle that completes on
                    // the limit-th wait state is still a good cycle.
                    w_next    = T4;
                    w_capture = !r_write;
                end else if ((r_state == TW) && w_limit_hit) begin
                    w_next  = T4;
                    w_abort = 1'b1;
                end else begin
                    w_next      = TW;
                    w_wait_incr = 1'b1;
                end
            end
            T4: begin
                // Accepting here chains straight into T1 so back-to-back
                // transfers run with no idle gap.
                w_next = w_accept ? T1 : IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Transfer latches, error flag and read-data capture
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_write <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
        end else begin
            if (w_accept) begin
                r_addr  <= bus.req_addr;
                r_wdata <= bus.req_wdata;
                r_write <= bus.req_write;
                r_err   <= 1'b0;
            end else if (w_abort) begin
                r_err   <= 1'b1;
            end

            if (w_capture) begin
                r_rdata <= bus.mem_rd_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Strobes decode straight from the state register so that an
    // asynchronous reset drops them immediately.
    // ------------------------------------------------------------------
    assign bus.req_ready   = w_req_ready;
    assign bus.ale         = (r_state == T1);

    // The write strobe follows READY combinationally, so exactly one write
    // lands, in the data-phase cycle that completes the transfer.
    assign bus.mem_wr_en   = r_write && w_data_phase && bus.bus_ready;
    assign bus.mem_rd_en   = !r_write && ((r_state == T2) || w_data_phase);

    assign bus.mem_wr_addr = r_addr;
    assign bus.mem_rd_addr = r_addr;
    assign bus.mem_wr_data = r_wdata;

    assign bus.resp_valid  = (r_state == T4);
    assign bus.resp_err    = (r_state == T4) && r_err;
    assign bus.resp_rdata  = r_rdata;

endmodule : bus_cycle_controller
`default_nettype wire

// File: tb/tb_bus_cycle_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_cycle_controller
//  Description : Self-checking bench for bus_cycle_controller. Expected
//                responses are queued when a request is driven and popped
//                when resp_valid pulses. A small byte memory sits on the
//                memory port.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_bus_cycle_controller;
    import bus_pkg::*;

    localparam int DW = 8;
    localparam int AW = 20;
    localparam int WL = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bus_cycle_controller_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) bus ();

    bus_cycle_controller #(
        .DATA_WIDTH    (DW),
        .ADDRESS_WIDTH (AW),
        .WAIT_LIMIT    (WL)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Memory emulation (low address byte selects the location)
    logic [7:0] mem [0:255];
    always @(posedge clk) begin
        if (bus.mem_wr_en) mem[bus.mem_wr_addr[7:0]] <= bus.mem_wr_data;
    end
    assign bus.mem_rd_data = mem[bus.mem_rd_addr[7:0]];

    // Reference model and scoreboard
    typedef struct {
        logic [7:0] rdata;
        logic       err;
        int         lat;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] ref_mem [0:255];
    logic [7:0] ref_rdata = 8'h00;

    int errors = 0;
    int checks = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_expect(input logic wr, input logic [19:0] addr,
                               input logic [7:0] wdata, input int nlow);
        exp_t e;
        e.err = (nlow > WL);
        e.lat = e.err ? (4 + WL) : (4 + nlow);
        if (!e.err && !wr) ref_rdata = ref_mem[addr[7:0]];
        if (!e.err && wr)  ref_mem[addr[7:0]] = wdata;
        e.rdata = ref_rdata;
        sb.push_back(e);
    endtask

    task automatic check_resp(input int k);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL sb_empty: unexpected resp_valid at cycle %0d", k);
        end else begin
            e = sb.pop_front();
            checks += 3;
            if (bus.resp_rdata !== e.rdata) begin
                errors++;
                $display("FAIL resp_rdata: got %02h want %02h", bus.resp_rdata, e.rdata);
            end
            if (bus.resp_err !== e.err) begin
                errors++;
                $display("FAIL resp_err: got %0b want %0b", bus.resp_err, e.err);
            end
            if (k != e.lat) begin
                errors++;
                $display("FAIL latency: got %0d want %0d", k, e.lat);
            end
        end
    endtask

    // Wait (bounded) until the currently driven request is accepted.
    task automatic wait_accept(output bit acc);
        acc = 1'b0;
        for (int i = 0; i < 10 && !acc; i++) begin
            @(negedge clk);
            if (bus.req_ready) acc = 1'b1;
        end
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL accept_timeout: req_ready got 0 want 1");
        end
    endtask

    // Run one transfer; READY is low for the first nlow data-phase cycles.
    task automatic do_xfer(input logic wr, input logic [19:0] addr,
                           input logic [7:0] wdata, input int nlow,
                           output int ale_cnt, output int wr_cnt, output int rd_cnt);
        bit acc;
        bit done;
        ale_cnt = 0; wr_cnt = 0; rd_cnt = 0; done = 1'b0;
        tick();
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.bus_ready = 1'b1;
        push_expect(wr, addr, wdata, nlow);
        wait_accept(acc);
        if (!acc) begin
            bus.req_valid = 1'b0;
            void'(sb.pop_back());
            return;
        end
        for (int k = 1; k <= 40 && !done; k++) begin
            tick();
            bus.req_valid = 1'b0;
            bus.bus_ready = (k >= 3 && k < 3 + nlow) ? 1'b0 : 1'b1;
            @(negedge clk);
            checks++;
            if (bus.ale !== (k == 1)) begin
                errors++;
                $display("FAIL ale_timing: cycle %0d got %0b want %0b", k, bus.ale, (k == 1));
            end
            if (bus.ale) ale_cnt++;
            if (bus.mem_rd_en) rd_cnt++;
            if (bus.mem_wr_en) begin
                wr_cnt++;
                checks += 2;
                if (bus.mem_wr_addr !== addr) begin
                    errors++;
                    $display("FAIL wr_addr: got %05h want %05h", bus.mem_wr_addr, addr);
                end
                if (bus.mem_wr_data !== wdata) begin
                    errors++;
                    $display("FAIL wr_data: got %02h want %02h", bus.mem_wr_data, wdata);
                end
            end
            if (bus.resp_valid) begin
                done = 1'b1;
                checks++;
                if (bus.mem_rd_addr !== addr) begin
                    errors++;
                    $display("FAIL rd_addr: got %05h want %05h", bus.mem_rd_addr, addr);
                end
                check_resp(k);
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL resp_timeout: resp_valid got 0 want 1");
            void'(sb.pop_front());
        end
        bus.bus_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks += 6;
        if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready: got %0b want 1", bus.req_ready); end
        if (bus.ale !== 1'b0)       begin errors++; $display("FAIL rst_ale: got %0b want 0", bus.ale); end
        if (bus.mem_wr_en !== 1'b0 || bus.mem_rd_en !== 1'b0) begin
            errors++; $display("FAIL rst_strobes: got wr=%0b rd=%0b want 0", bus.mem_wr_en, bus.mem_rd_en);
        end
        if (bus.resp_valid !== 1'b0 || bus.resp_err !== 1'b0) begin
            errors++; $display("FAIL rst_resp: got v=%0b e=%0b want 0", bus.resp_valid, bus.resp_err);
        end
        if (bus.resp_rdata !== 8'h00) begin errors++; $display("FAIL rst_rdata: got %02h want 00", bus.resp_rdata); end
        if (bus.mem_wr_addr !== 20'h0 || bus.mem_wr_data !== 8'h00) begin
            errors++; $display("FAIL rst_latches: got %05h/%02h want 0", bus.mem_wr_addr, bus.mem_wr_data);
        end
        rst = 1'b0;
    endtask

    task automatic test_write();
        int a, w, r;
        do_xfer(1'b1, 20'h12345, 8'hA5, 0, a, w, r);
        checks += 4;
        if (a != 1) begin errors++; $display("FAIL wr_ale_count: got %0d want 1", a); end
        if (w != 1) begin errors++; $display("FAIL wr_pulses: got %0d want 1", w); end
        if (r != 0) begin errors++; $display("FAIL wr_rd_en: got %0d want 0", r); end
        @(negedge clk);
        if (bus.mem_wr_addr !== 20'h12345) begin
            errors++; $display("FAIL wr_addr_hold: got %05h want 12345", bus.mem_wr_addr);
        end
    endtask

    task automatic test_read(input int nlow, input string name);
        int a, w, r;
        do_xfer(1'b0, 20'h12345, 8'h00, nlow, a, w, r);
        checks += 2;
        if (w != 0) begin errors++; $display("FAIL %s_wr_pulses: got %0d want 0", name, w); end
        if (r != 2 + nlow) begin errors++; $display("FAIL %s_rd_en_cycles: got %0d want %0d", name, r, 2 + nlow); end
    endtask

    task automatic test_abort();
        int a, w, r;
        do_xfer(1'b1, 20'h00777, 8'h5A, 1000, a, w, r);
        checks++;
        if (w != 0) begin errors++; $display("FAIL abort_wr_pulses: got %0d want 0", w); end
    endtask

    task automatic test_back_to_back();
        bit acc;
        bit acc2 = 1'b0;
        int r1 = -1;
        int r2 = -1;
        int wr_cnt = 0;
        tick();
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_addr  = 20'h00001;
        bus.req_wdata = 8'h3C;
        bus.bus_ready = 1'b1;
        push_expect(1'b1, 20'h00001, 8'h3C, 0);
        wait_accept(acc);
        if (!acc) begin bus.req_valid = 1'b0; void'(sb.pop_back()); return; end
        tick();
        // Valid stays high while the write is in flight; it must be ignored.
        bus.req_write = 1'b0;
        bus.req_wdata = 8'hFF;
        push_expect(1'b0, 20'h00001, 8'h00, 0);
        for (int k = 1; k <= 30 && r2 < 0; k++) begin
            if (k > 1) tick();
            if (acc2) bus.req_valid = 1'b0;
            @(negedge clk);
            if (bus.mem_wr_en) wr_cnt++;
            if (bus.resp_valid) begin
                if (r1 < 0) begin
                    r1 = k;
                    check_resp(k);
                    checks++;
                    if (bus.req_ready !== 1'b1) begin
                        errors++; $display("FAIL b2b_accept_t4: req_ready got %0b want 1", bus.req_ready);
                    end
                    acc2 = 1'b1;
                end else begin
                    r2 = k;
                    check_resp(k - r1);
                end
            end
        end
        bus.req_valid = 1'b0;
        checks += 2;
        if (r2 - r1 != 4 || r1 < 0) begin
            errors++; $display("FAIL b2b_spacing: got %0d want 4", r2 - r1);
        end
        if (wr_cnt != 1) begin errors++; $display("FAIL b2b_wr_pulses: got %0d want 1", wr_cnt); end
    endtask

    // Reset while a transfer sits in TW; it must vanish without a trace.
    task automatic test_reset_mid(input logic wr);
        bit acc;
        int resp_seen = 0;
        int wr_seen = 0;
        tick();
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_addr  = 20'h12345;
        bus.req_wdata = 8'h99;
        bus.bus_ready = 1'b1;
        wait_accept(acc);
        for (int k = 1; k <= 5; k++) begin
            tick();
            bus.req_valid = 1'b0;
            bus.bus_ready = (k >= 3) ? 1'b0 : 1'b1;
        end
        @(negedge clk);
        checks++;
        if (bus.mem_rd_en !== !wr) begin
            errors++; $display("FAIL rstmid_pre_rd_en: got %0b want %0b", bus.mem_rd_en, !wr);
        end
        rst = 1'b1;
        #1;
        checks += 3;
        if (bus.ale !== 1'b0 || bus.mem_wr_en !== 1'b0 || bus.mem_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_strobes: got ale=%0b wr=%0b rd=%0b want 0", bus.ale, bus.mem_wr_en, bus.mem_rd_en);
        end
        if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_idle: req_ready got %0b want 1", bus.req_ready); end
        if (bus.mem_wr_addr !== 20'h0) begin errors++; $display("FAIL rstmid_addr: got %05h want 0", bus.mem_wr_addr); end
        @(negedge clk);
        rst = 1'b0;
        bus.bus_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (bus.resp_valid) resp_seen++;
            if (bus.mem_wr_en) wr_seen++;
        end
        checks += 2;
        if (resp_seen != 0) begin errors++; $display("FAIL rstmid_resp: got %0d want 0", resp_seen); end
        if (wr_seen != 0)   begin errors++; $display("FAIL rstmid_write: got %0d want 0", wr_seen); end
        // A normal read afterwards must still see the original byte.
        test_read(0, "post_rst");
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.bus_ready = 1'b1;
        test_reset();
        test_write();
        test_read(0, "read");
        test_read(3, "read_w3");
        test_read(WL, "read_wlimit");
        test_abort();
        test_back_to_back();
        test_reset_mid(1'b1);
        test_reset_mid(1'b0);
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL sb_leftover: got %0d want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule : tb_bus_cycle_controller
`default_nettype wire
